// File: rtl/id_ex_register_pkg.sv
// rtl/id_ex_register_pkg.sv - shared decoder encodings and control bundle for the ID/EX stage
package id_ex_register_pkg;

  // ALUOp encodings produced by the main decoder
  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // x0 register index
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control bits that travel with the instruction into EX/MEM/WB
  typedef struct packed {
    logic       memtoreg;
    logic [1:0] aluop;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
  } ctrl_t;

  // Bubble: no memory access, no writeback
  localparam ctrl_t CTRL_NOP = '{memtoreg: 1'b0, aluop: ALUOP_LDST, memwrite: 1'b0,
                                 alusrc: 1'b0, regwrite: 1'b0};

endpackage

// File: rtl/id_ex_register_load_use_detect.sv
// rtl/id_ex_register_load_use_detect.sv - combinational load-use hazard detection
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              valid_i,
  input  logic              branch_i,
  input  logic              memwrite_i,
  input  logic              alusrc_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              ex_valid_i,
  input  logic              ex_memtoreg_i,
  input  logic              ex_regwrite_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  output logic              hazard_o
);

  logic use_rs1;
  logic use_rs2;
  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // rs2 is only read when it is a real operand: R-type, store data, or branch compare
  always_comb begin
    use_rs1    = valid_i;
    use_rs2    = valid_i & (~alusrc_i | memwrite_i | branch_i);
    // a load targeting x0 produces nothing to wait for
    ex_is_load = ex_valid_i & ex_memtoreg_i & ex_regwrite_i &
                 (ex_rd_addr_i != {REG_AW{1'b0}});
    rs1_match  = use_rs1 & (rs1_addr_i == ex_rd_addr_i);
    rs2_match  = use_rs2 & (rs2_addr_i == ex_rd_addr_i);
    hazard_o   = ex_is_load & (rs1_match | rs2_match);
  end

endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with load-use stall and perf counters
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              branch_i,
  input  logic              memtoreg_i,
  input  logic [1:0]        aluop_i,
  input  logic              memwrite_i,
  input  logic              alusrc_i,
  input  logic              regwrite_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [9:0]        funct_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              ex_memtoreg_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_memwrite_o,
  output logic              ex_alusrc_o,
  output logic              ex_regwrite_o,
  output logic [REG_AW-1:0] ex_rs1_addr_o,
  output logic [REG_AW-1:0] ex_rs2_addr_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic [DATA_W-1:0] ex_rs1_data_o,
  output logic [DATA_W-1:0] ex_rs2_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [9:0]        ex_funct_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;
  logic  bubble;

  assign id_ctrl = '{memtoreg: memtoreg_i, aluop: aluop_i, memwrite: memwrite_i,
                     alusrc: alusrc_i, regwrite: regwrite_i};

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .valid_i       (valid_i),
    .branch_i      (branch_i),
    .memwrite_i    (memwrite_i),
    .alusrc_i      (alusrc_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .ex_valid_i    (ex_valid_o),
    .ex_memtoreg_i (ex_ctrl.memtoreg),
    .ex_regwrite_i (ex_ctrl.regwrite),
    .ex_rd_addr_i  (ex_rd_addr_o),
    .hazard_o      (hazard)
  );

  // flush kills the ID instruction, so it overrides the stall; reset EX state already
  // forces hazard low, so stall_o is 0 while rst_i is held
  assign stall_o = hazard & ~flush_i;
  assign bubble  = flush_i | hazard | ~valid_i;

  // ID/EX bank: bubbles zero valid and control, data fields always follow the inputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_ctrl       <= CTRL_NOP;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_funct_o    <= '0;
    end else begin
      ex_valid_o    <= ~bubble;
      ex_ctrl       <= bubble ? CTRL_NOP : id_ctrl;
      ex_rs1_addr_o <= rs1_addr_i;
      ex_rs2_addr_o <= rs2_addr_i;
      ex_rd_addr_o  <= rd_addr_i;
      ex_rs1_data_o <= rs1_data_i;
      ex_rs2_data_o <= rs2_data_i;
      ex_imm_o      <= imm_i;
      ex_funct_o    <= funct_i;
    end
  end

  // Saturating stall and flush counters for performance debug
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_i && (flush_cnt_o != {CNT_W{1'b1}})) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

  assign ex_memtoreg_o = ex_ctrl.memtoreg;
  assign ex_aluop_o    = ex_ctrl.aluop;
  assign ex_memwrite_o = ex_ctrl.memwrite;
  assign ex_alusrc_o   = ex_ctrl.alusrc;
  assign ex_regwrite_o = ex_ctrl.regwrite;

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - scoreboard bench for id_ex_register
module tb_id_ex_register;
  import id_ex_register_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i, branch_i, memtoreg_i, memwrite_i, alusrc_i, regwrite_i, flush_i;
  logic [1:0]        aluop_i;
  logic [REG_AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [DATA_W-1:0] rs1_data_i, rs2_data_i, imm_i;
  logic [9:0]        funct_i;
  logic              stall_o, ex_valid_o, ex_memtoreg_o, ex_memwrite_o, ex_alusrc_o, ex_regwrite_o;
  logic [1:0]        ex_aluop_o;
  logic [REG_AW-1:0] ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
  logic [DATA_W-1:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [9:0]        ex_funct_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  id_ex_register #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .branch_i(branch_i),
    .memtoreg_i(memtoreg_i), .aluop_i(aluop_i), .memwrite_i(memwrite_i),
    .alusrc_i(alusrc_i), .regwrite_i(regwrite_i), .rs1_addr_i(rs1_addr_i),
    .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .funct_i(funct_i), .flush_i(flush_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_memtoreg_o(ex_memtoreg_o),
    .ex_aluop_o(ex_aluop_o), .ex_memwrite_o(ex_memwrite_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_rs1_addr_o(ex_rs1_addr_o),
    .ex_rs2_addr_o(ex_rs2_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_funct_o(ex_funct_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {K_NOP, K_R, K_I, K_LD, K_ST, K_BR} kind_e;

  typedef struct {
    bit        valid, branch, load, memwrite, alusrc, regwrite;
    bit [1:0]  aluop;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] d1, d2, imm;
    bit [9:0]  funct;
  } instr_t;

  typedef struct {
    bit        valid, load, memwrite, alusrc, regwrite;
    bit [1:0]  aluop;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] d1, d2, imm;
    bit [9:0]  funct;
    int        scnt, fcnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference view of what instruction currently occupies EX
  bit       m_live_load;
  bit [4:0] m_rd;
  int       m_scnt, m_fcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(kind_e k, int rd, int rs1, int rs2, int imm);
    instr_t i;
    i.valid = (k != K_NOP);
    i.branch = (k == K_BR);
    i.load = (k == K_LD);
    i.memwrite = (k == K_ST);
    i.alusrc = (k == K_I) || (k == K_LD) || (k == K_ST);
    i.regwrite = (k == K_R) || (k == K_I) || (k == K_LD);
    case (k)
      K_R:     i.aluop = ALUOP_RTYPE;
      K_I:     i.aluop = ALUOP_ITYPE;
      K_BR:    i.aluop = ALUOP_BRANCH;
      default: i.aluop = ALUOP_LDST;
    endcase
    if (k == K_NOP) begin
      i.branch = 0; i.load = 0; i.memwrite = 0; i.alusrc = 0; i.regwrite = 0; i.aluop = 0;
    end
    i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.d1 = $urandom; i.d2 = $urandom; i.imm = 32'(imm);
    i.funct = 10'($urandom);
    return i;
  endfunction

  // A load in EX blocks any ID instruction that actually reads its (nonzero) destination
  function automatic bit model_hazard(instr_t i);
    bit reads_rs2;
    if (!m_live_load || m_rd == 0 || !i.valid) return 0;
    reads_rs2 = !i.alusrc || i.memwrite || i.branch;
    return (i.rs1 == m_rd) || (reads_rs2 && i.rs2 == m_rd);
  endfunction

  task automatic reset_model();
    m_live_load = 0; m_rd = 0; m_scnt = 0; m_fcnt = 0;
    q.delete();
  endtask

  // Drive one ID cycle; returns whether the reference expects a stall
  task automatic step(input instr_t i, input bit fl, output bit st);
    exp_t e;
    bit   hz, issue;
    @(negedge clk_i);
    valid_i = i.valid; branch_i = i.branch; memtoreg_i = i.load; aluop_i = i.aluop;
    memwrite_i = i.memwrite; alusrc_i = i.alusrc; regwrite_i = i.regwrite;
    rs1_addr_i = i.rs1; rs2_addr_i = i.rs2; rd_addr_i = i.rd;
    rs1_data_i = i.d1; rs2_data_i = i.d2; imm_i = i.imm; funct_i = i.funct; flush_i = fl;
    #1;
    hz = model_hazard(i);
    st = hz && !fl;
    check("stall_o", stall_o, st);
    issue = i.valid && !hz && !fl;
    e.valid = issue;
    e.load = issue && i.load; e.memwrite = issue && i.memwrite; e.alusrc = issue && i.alusrc;
    e.regwrite = issue && i.regwrite; e.aluop = issue ? i.aluop : 2'b00;
    e.rs1 = i.rs1; e.rs2 = i.rs2; e.rd = i.rd; e.d1 = i.d1; e.d2 = i.d2; e.imm = i.imm;
    e.funct = i.funct;
    if (st && m_scnt < CNT_MAX) m_scnt++;
    if (fl && m_fcnt < CNT_MAX) m_fcnt++;
    e.scnt = m_scnt; e.fcnt = m_fcnt;
    m_live_load = issue && i.load && i.regwrite;
    m_rd = i.rd;
    q.push_back(e);
  endtask

  // Monitor: after every clock edge compare EX against the oldest prediction
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (!rst_i && q.size() > 0) begin
      e = q.pop_front();
      check("ex_valid", ex_valid_o, e.valid);
      check("ex_ctrl", {ex_memtoreg_o, ex_aluop_o, ex_memwrite_o, ex_alusrc_o, ex_regwrite_o},
            {e.load, e.aluop, e.memwrite, e.alusrc, e.regwrite});
      check("ex_addr", {ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o}, {e.rs1, e.rs2, e.rd});
      check("ex_data", {ex_rs1_data_o, ex_rs2_data_o}, {e.d1, e.d2});
      check("ex_imm_funct", {ex_imm_o, ex_funct_o}, {e.imm, e.funct});
      check("counters", {stall_cnt_o, flush_cnt_o}, {4'(e.scnt), 4'(e.fcnt)});
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_ex"}, {ex_valid_o, ex_memtoreg_o, ex_aluop_o, ex_memwrite_o, ex_alusrc_o,
                         ex_regwrite_o, ex_rd_addr_o, ex_rs1_addr_o, ex_rs2_addr_o}, 0);
    check({tag, "_data"}, {ex_rs1_data_o, ex_rs2_data_o}, 0);
    check({tag, "_imm"}, {ex_imm_o, ex_funct_o}, 0);
    check({tag, "_cnt"}, {stall_cnt_o, flush_cnt_o}, 0);
    check({tag, "_stall"}, stall_o, 0);
  endtask

  initial begin
    instr_t cur, add_i;
    bit st;
    rst_i = 1'b1;
    valid_i = 0; branch_i = 0; memtoreg_i = 0; aluop_i = 0; memwrite_i = 0; alusrc_i = 0;
    regwrite_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0; rs1_data_i = 0;
    rs2_data_i = 0; imm_i = 0; funct_i = 0; flush_i = 0;
    reset_model();
    repeat (2) @(negedge clk_i);
    check_cleared("reset");
    rst_i = 1'b0;

    // add x3,x1,x2 passes through in one cycle
    cur = mk(K_R, 3, 1, 2, 0); cur.d1 = 5; cur.d2 = 7;
    step(cur, 0, st);
    @(posedge clk_i); #2;
    check("pass_valid", ex_valid_o, 1);
    check("pass_fields", {ex_rd_addr_o, ex_aluop_o, ex_regwrite_o}, {5'd3, 2'b10, 1'b1});
    check("pass_data", {ex_rs1_data_o, ex_rs2_data_o}, {32'd5, 32'd7});

    // lw x5,0(x1); add x6,x5,x2 -> one stall cycle then issue
    step(mk(K_LD, 5, 1, 0, 0), 0, st);
    add_i = mk(K_R, 6, 5, 2, 0);
    step(add_i, 0, st);
    check("lu_stall_hi", stall_o, 1);
    step(add_i, 0, st);
    check("lu_stall_lo", stall_o, 0);
    @(posedge clk_i); #2;
    check("lu_stall_cnt", stall_cnt_o, 1);

    // lw x5; addi x6,x7,4 with rs2 field 5 -> no stall
    step(mk(K_LD, 5, 1, 0, 0), 0, st);
    step(mk(K_I, 6, 7, 5, 4), 0, st);
    check("imm_no_stall", stall_o, 0);
    // lw x5; sw x5,0(x8) -> stall on store data
    step(mk(K_LD, 5, 1, 0, 0), 0, st);
    cur = mk(K_ST, 0, 8, 5, 0);
    step(cur, 0, st);
    check("sw_stall", stall_o, 1);
    step(cur, 0, st);

    // lw x0; add x1,x0,x0 -> no stall; add x5; sub x6,x5 -> no stall
    step(mk(K_LD, 0, 1, 0, 0), 0, st);
    step(mk(K_R, 1, 0, 0, 0), 0, st);
    check("x0_no_stall", stall_o, 0);
    step(mk(K_R, 5, 1, 2, 0), 0, st);
    step(mk(K_R, 6, 5, 3, 0), 0, st);
    check("alu_no_stall", stall_o, 0);

    // flush in the same cycle as a load-use hazard
    step(mk(K_LD, 5, 1, 0, 0), 0, st);
    step(mk(K_R, 6, 5, 2, 0), 1, st);
    check("flush_hz_stall", stall_o, 0);
    @(posedge clk_i); #2;
    check("flush_cnt", flush_cnt_o, 1);
    check("flush_bubble", ex_valid_o, 0);

    // reset asserted mid-stall clears everything without a clock edge
    step(mk(K_LD, 5, 1, 0, 0), 0, st);
    step(mk(K_R, 6, 5, 2, 0), 0, st);
    #2 rst_i = 1'b1;
    q.delete();
    #1 check_cleared("midrst");
    @(negedge clk_i);
    rst_i = 1'b0;
    reset_model();
    #1 check("post_rst_stall", stall_o, 0);

    // stall counter saturation (CNT_W = 4)
    for (int n = 0; n < 20; n++) begin
      step(mk(K_LD, 4, 1, 0, 0), 0, st);
      cur = mk(K_BR, 0, 2, 4, 0);
      step(cur, 0, st);
      if (st) step(cur, 0, st);
    end
    @(posedge clk_i); #2;
    check("stall_sat", stall_cnt_o, CNT_MAX);

    // randomized traffic against the reference
    cur = mk(K_NOP, 0, 0, 0, 0);
    st = 0;
    for (int n = 0; n < 800; n++) begin
      if (!st) begin
        cur = mk(kind_e'($urandom_range(0, 5)), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom);
      end
      step(cur, ($urandom_range(0, 19) == 0), st);
    end
    step(mk(K_NOP, 0, 0, 0, 0), 0, st);
    repeat (3) @(posedge clk_i);
    #2 check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
